// File: rtl/mem_access_unit.sv
// Load/store sequencer between decoder, data memory and the GP register file.
// Optional MAU_TIMEOUT_EN: abort a memory request after TIMEOUT cycles without ack.
module mem_access_unit #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_store,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [2:0]        op_sel_z,
   input  logic [31:0]       op_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        MemInstruction,
   output logic [31:0]       MemData,
   output logic [2:0]        SelZ,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [1:0] MI_NOP = 2'b00;
   localparam logic [1:0] MI_RD  = 2'b01;
   localparam logic [1:0] MI_WR  = 2'b10;
   localparam logic [1:0] MI_GP  = 2'b11;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t state, state_nx;

   logic              req_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [31:0]       wdata_d;
   logic [31:0]       data_d;
   logic [2:0]        sel_d;
   logic [1:0]        ins_d;
   logic              abort;

   assign op_ready = (state == IDLE);
   assign busy     = ~op_ready;

`ifdef MAU_TIMEOUT_EN
   logic [7:0] cnt, cnt_d;

   // Abort only when the last allowed REQ edge passes without an ack.
   assign abort = (state == REQ) & ~mem_ack & (cnt == TO_LAST);

   always_comb begin
      cnt_d = cnt;
      if (state == IDLE)
         cnt_d = 8'd0;
      else if (state == REQ && !mem_ack)
         cnt_d = cnt + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_d;
         err <= abort;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^TO_LAST;
   assign abort      = 1'b0;
   assign err        = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= 32'd0;
         MemInstruction <= MI_NOP;
         MemData        <= 32'd0;
         SelZ           <= 3'd0;
      end else begin
         state          <= state_nx;
         mem_req        <= req_d;
         mem_we         <= we_d;
         mem_addr       <= addr_d;
         mem_wdata      <= wdata_d;
         MemInstruction <= ins_d;
         MemData        <= data_d;
         SelZ           <= sel_d;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (op_valid)
               state_nx = REQ;
         end
         REQ: begin
            if (mem_ack)
               state_nx = mem_we ? IDLE : WB;
            else if (abort)
               state_nx = IDLE;
         end
         WB: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      req_d   = mem_req;
      we_d    = mem_we;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      data_d  = MemData;
      sel_d   = SelZ;
      ins_d   = MemInstruction;
      unique case (state)
         IDLE: begin
            if (op_valid) begin
               req_d   = 1'b1;
               we_d    = op_store;
               addr_d  = op_addr;
               wdata_d = op_wdata;
               sel_d   = op_sel_z;
               ins_d   = op_store ? MI_WR : MI_RD;
            end
         end
         REQ: begin
            if (mem_ack) begin
               req_d = 1'b0;
               if (mem_we) begin
                  ins_d = MI_NOP;
               end else begin
                  ins_d  = MI_GP;
                  data_d = mem_rdata;
               end
            end else if (abort) begin
               req_d = 1'b0;
               ins_d = MI_NOP;
            end
         end
         WB: begin
            ins_d = MI_NOP;
         end
         default: begin
            ins_d = MI_NOP;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
// Timeout cases are exercised only when MAU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic        op_store = 1'b0;
   logic [15:0] op_addr = 16'd0;
   logic [2:0]  op_sel_z = 3'd0;
   logic [31:0] op_wdata = 32'd0;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [1:0]  MemInstruction;
   logic [31:0] MemData;
   logic [2:0]  SelZ;
   logic        busy;
   logic        err;

   mem_access_unit #(.ADDR_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_store(op_store), .op_addr(op_addr),
      .op_sel_z(op_sel_z), .op_wdata(op_wdata),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .MemInstruction(MemInstruction), .MemData(MemData),
      .SelZ(SelZ), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one outstanding transaction plus a pending writeback.
   logic        m_pend, m_wb, m_we, m_err;
   logic [15:0] m_addr;
   logic [31:0] m_wdata, m_data;
   logic [2:0]  m_sel;
   logic [1:0]  m_ins;
   int          m_age;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 0; m_wb = 0; m_we = 0; m_err = 0;
         m_addr = 0; m_wdata = 0; m_data = 0; m_sel = 0;
         m_ins = 0; m_age = 0;
      end else begin
         m_err = 0;
         if (m_wb) begin
            m_wb  = 0;
            m_ins = 2'b00;
         end else if (m_pend) begin
            if (mem_ack) begin
               m_pend = 0;
               if (m_we) begin
                  m_ins = 2'b00;
               end else begin
                  m_ins  = 2'b11;
                  m_data = mem_rdata;
                  m_wb   = 1;
               end
            end else begin
               m_age++;
`ifdef MAU_TIMEOUT_EN
               if (m_age == 4) begin
                  m_pend = 0;
                  m_ins  = 2'b00;
                  m_err  = 1;
               end
`endif
            end
         end else if (op_valid) begin
            m_pend  = 1;
            m_age   = 0;
            m_we    = op_store;
            m_addr  = op_addr;
            m_wdata = op_wdata;
            m_sel   = op_sel_z;
            m_ins   = op_store ? 2'b10 : 2'b01;
         end
      end
   end

   // Event counters: 0 req, 1 ins01, 2 ins10, 3 ins11, 4 err, 5 req&we
   int          cnt [0:5];
   int          base[0:5];
   logic [31:0] last_data = 32'd0;
   logic [2:0]  last_sel = 3'd0;

   initial for (int i = 0; i < 6; i++) cnt[i] = 0;

   always begin
      @(posedge clk);
      #1;
      check("mem_req", mem_req, m_pend);
      check("op_ready", op_ready, !(m_pend || m_wb));
      check("busy", busy, m_pend || m_wb);
      check("mem_we", mem_we, m_we);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("MemInstr", MemInstruction, m_ins);
      check("MemData", MemData, m_data);
      check("SelZ", SelZ, m_sel);
      check("err", err, m_err);
      if (mem_req) cnt[0]++;
      if (MemInstruction == 2'b01) cnt[1]++;
      if (MemInstruction == 2'b10) cnt[2]++;
      if (MemInstruction == 2'b11) begin
         cnt[3]++;
         last_data = MemData;
         last_sel  = SelZ;
      end
      if (err) cnt[4]++;
      if (mem_req && mem_we) cnt[5]++;
   end

   task automatic snap();
      for (int i = 0; i < 6; i++) base[i] = cnt[i];
   endtask

   function automatic int dlt(input int i);
      return cnt[i] - base[i];
   endfunction

   // Called on a negedge; returns on a negedge. waits < 0 means never ack.
   task automatic do_op(input logic st, input logic [15:0] a,
                        input logic [31:0] d, input logic [2:0] s,
                        input int waits, input logic [31:0] rd,
                        output int acc);
      int n = 0;
      op_valid = 1; op_store = st; op_addr = a; op_wdata = d; op_sel_z = s;
      while (!op_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("op_accept", op_ready, 1'b1);
      acc = cyc + 1;
      if (!op_ready) begin
         op_valid = 0;
         return;
      end
      @(negedge clk);
      op_valid = 0;
      if (waits >= 0) begin
         repeat (waits) @(negedge clk);
         mem_ack = 1; mem_rdata = rd;
         @(negedge clk);
         mem_ack = 0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, r0;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      check("rst_ready", op_ready, 1'b1);
      check("rst_ins", MemInstruction, 2'b00);

      // Zero-wait load
      snap();
      do_op(0, 16'h0010, 32'd0, 3'd5, 0, 32'hDEADBEEF, a1);
      repeat (3) @(negedge clk);
      check("ld_req_cycles", dlt(0), 1);
      check("ld_01_cycles", dlt(1), 1);
      check("ld_11_cycles", dlt(3), 1);
      check("ld_data", last_data, 32'hDEADBEEF);
      check("ld_sel", last_sel, 3'd5);

      // Store with 3 wait states
      snap();
      do_op(1, 16'h00FF, 32'h12345678, 3'd0, 3, 32'd0, a1);
      repeat (2) @(negedge clk);
      check("st_req_cycles", dlt(0), 4);
      check("st_we_cycles", dlt(5), 4);
      check("st_10_cycles", dlt(2), 4);
      check("st_11_cycles", dlt(3), 0);

      // Back-to-back load then store, then stray ack while idle
      snap();
      do_op(0, 16'h0101, 32'd0, 3'd2, 0, 32'hCAFEF00D, a1);
      do_op(1, 16'h0202, 32'h55AA55AA, 3'd0, 0, 32'd0, a2);
      check("b2b_gap", a2 - a1, 3);
      r0 = dlt(0);
      mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      mem_ack = 0;
      repeat (2) @(negedge clk);
      check("stray_req", dlt(0) - r0, 0);
      check("stray_data", MemData, 32'hCAFEF00D);

      // Asynchronous reset in the middle of a store request
      op_valid = 1; op_store = 1; op_addr = 16'h1234;
      op_wdata = 32'hA5A5A5A5; op_sel_z = 3'd7;
      @(negedge clk);
      op_valid = 0;
      check("pre_rst_we", mem_we, 1'b1);
      #2 rst = 1;
      #1;
      check("arst_req", mem_req, 1'b0);
      check("arst_we", mem_we, 1'b0);
      check("arst_addr", mem_addr, 16'h0);
      check("arst_wdata", mem_wdata, 32'h0);
      check("arst_ins", MemInstruction, 2'b00);
      check("arst_data", MemData, 32'h0);
      check("arst_sel", SelZ, 3'd0);
      check("arst_ready", op_ready, 1'b1);
      check("arst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 0;

      // Reset during a load request: no writeback, then normal load
      snap();
      op_valid = 1; op_store = 0; op_addr = 16'h0020; op_sel_z = 3'd3;
      @(negedge clk);
      op_valid = 0;
      #2 rst = 1;
      @(negedge clk);
      rst = 0;
      mem_ack = 1; mem_rdata = 32'h11111111;
      @(negedge clk);
      mem_ack = 0;
      repeat (3) @(negedge clk);
      check("rst_ld_11", dlt(3), 0);
      do_op(0, 16'h0030, 32'd0, 3'd6, 1, 32'h0BADC0DE, a1);
      repeat (2) @(negedge clk);
      check("post_rst_11", dlt(3), 1);
      check("post_rst_sel", last_sel, 3'd6);
      check("post_rst_data", last_data, 32'h0BADC0DE);

`ifdef MAU_TIMEOUT_EN
      snap();
      do_op(1, 16'h0040, 32'h1, 3'd0, -1, 32'd0, a1);
      repeat (6) @(negedge clk);
      check("to_req_cycles", dlt(0), 4);
      check("to_err", dlt(4), 1);
      check("to_11", dlt(3), 0);
      snap();
      do_op(0, 16'h0041, 32'd0, 3'd2, 3, 32'h00000077, a1);
      repeat (3) @(negedge clk);
      check("to_ack_req", dlt(0), 4);
      check("to_ack_err", dlt(4), 0);
      check("to_ack_11", dlt(3), 1);
      check("to_ack_data", last_data, 32'h77);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer that sits between the instruction decoder and external data memory and is the driving end of the general-purpose register file's memory bus. It accepts one load or store operation at a time, runs a req/ack transaction to memory, and for loads returns the fetched word to the register file by presenting MemInstruction = 2'b11 with MemData/SelZ for exactly one clock. Stores take their write data from the register file's A read port via the decoder.

## Interface
- ADDR_W, 16, memory word-address width
- TIMEOUT, 255, maximum mem_req cycles before abort (1..255); used only when MAU_TIMEOUT_EN is defined

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  decoder presents an operation
- op_ready  out  1  unit idle, operation accepted on edge where op_valid & op_ready
- op_store  in  1  1 = store, 0 = load
- op_addr  in  ADDR_W  memory address
- op_sel_z  in  3  destination register index (loads)
- op_wdata  in  32  store data
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write transaction
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completes transaction on this edge
- mem_rdata  in  32  read data, valid with mem_ack on a read
- MemInstruction  out  2  00 NOP, 01 read from mem, 10 write to mem, 11 data to GP registers
- MemData  out  32  load data to register file
- SelZ  out  3  destination register to register file
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, REQ, WB. All outputs registered except op_ready = (state == IDLE) and busy = ~op_ready.
- IDLE: on op_valid: latch op_addr, op_wdata, op_sel_z, op_store into mem_addr, mem_wdata, SelZ, mem_we; mem_req <= 1; MemInstruction <= 01 (load) or 10 (store); go REQ.
- REQ: mem_req and all mem_* outputs stable. On mem_ack:
  - load: MemData <= mem_rdata, MemInstruction <= 11, mem_req <= 0, go WB.
  - store: MemInstruction <= 00, mem_req <= 0, go IDLE.
- WB: one cycle; MemInstruction <= 00, go IDLE. The register file writes MemData into register SelZ on the edge ending WB.
- mem_ack in IDLE or WB ignored. op_valid while not ready ignored; upstream holds it.
- MemData, SelZ, mem_addr, mem_wdata, mem_we hold their last values outside active states.
- Reset (any state, including mid-REQ or WB): state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, MemInstruction 00, MemData 0, SelZ 0, err 0, timeout counter 0. Abandoned transaction produces no writeback.

## Timing
- Accept edge E0; mem_req high from E0.
- Zero-wait memory (ack sampled at E1): load MemInstruction = 11 during E1..E2, register written at E2, op_ready high after E2. Minimum load occupancy 2 cycles; store 1 cycle; op_ready high after E1.
- Each wait state adds one cycle; mem_req stays high for (wait states + 1) cycles.
- Back-to-back: new op may be accepted on the edge after returning to IDLE; no bubble beyond that.

## Configuration
- MAU_TIMEOUT_EN defined: 8-bit counter clears on entry to REQ and increments each REQ cycle without ack. mem_req is held for at most TIMEOUT cycles. If ack is absent on the TIMEOUT-th REQ edge: mem_req <= 0, MemInstruction <= 00, err pulses 1 for one cycle, go IDLE, no writeback. Ack on that same edge wins and completes normally.
- Undefined: no counter; REQ waits indefinitely; err tied 0.

## Test plan
- Assert rst asynchronously mid-cycle -> all registered outputs 0 immediately, op_ready 1, busy 0.
- Load addr 0x0010, sel 5, ack next cycle with rdata 0xDEADBEEF -> MemInstruction 01 for 1 cycle, then 11 with MemData 0xDEADBEEF, SelZ 5 for exactly 1 cycle, then 00.
- Store addr 0x00FF, data 0x12345678, ack after 3 wait states -> mem_req, mem_we 1 for 4 cycles with stable addr and data, MemInstruction 10 throughout, never 11.
- Back-to-back load then store with zero-wait memory -> second op accepted the cycle after WB; stray mem_ack pulse while IDLE causes no change.
- MAU_TIMEOUT_EN, TIMEOUT = 4, no ack -> mem_req high exactly 4 cycles, err pulses once, no 11 issued; repeat with ack on 4th cycle -> normal completion, err 0.
- rst asserted during REQ of a load, then released -> no MemInstruction 11 ever appears; next op proceeds normally.
